// File: rtl/ld_pkg.sv
// Shared types, op counts and microprogram ROMs for the Lopez-Dahab point ALU.
// ROM operands are XOR masks over the source table, so field additions cost no cycles.
package ld_pkg;

  localparam int LD_M = 4;
  typedef logic [LD_M-1:0] field_t;
  typedef struct packed {
    field_t z;
    field_t y;
    field_t x;
  } point_t;

  localparam int NMUL_DBL = 10;
  localparam int NMUL_ADD = 14;
  localparam int NSRC     = 16;
  localparam int NSCR     = 8;

  typedef enum logic [3:0] {
    S_X1, S_Y1, S_Z1, S_X2, S_Y2, S_ONE, S_CA, S_CB,
    S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7
  } src_e;

  typedef logic [NSRC-1:0] src_mask_t;
  typedef logic [2:0]      dst_t;

  typedef struct packed {
    src_mask_t sel_a;
    src_mask_t sel_b;
    dst_t      dst;
  } uop_t;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FINISH} state_e;

  function automatic src_mask_t sm(src_e s);
    src_mask_t m;
    m    = '0;
    m[s] = 1'b1;
    return m;
  endfunction

  function automatic uop_t mk(src_mask_t a, src_mask_t b, src_e d);
    uop_t u;
    u.sel_a = a;
    u.sel_b = b;
    u.dst   = 3'(int'(d) - int'(S_T0));
    return u;
  endfunction

  function automatic int latency(int m, logic op);
    return (op ? NMUL_DBL : NMUL_ADD) * (m + 1) + 1;
  endfunction

  // Doubling: T0=X^2..X^4, T1=Z^2..bZ^4, T2=Z3, T3=Y^2, T4=aZ3, T5=bZ^4*Z3
  localparam uop_t DBL_ROM [NMUL_DBL] = '{
    mk(sm(S_X1), sm(S_X1), S_T0),
    mk(sm(S_Z1), sm(S_Z1), S_T1),
    mk(sm(S_T0), sm(S_T1), S_T2),
    mk(sm(S_T0), sm(S_T0), S_T0),
    mk(sm(S_T1), sm(S_T1), S_T1),
    mk(sm(S_CB), sm(S_T1), S_T1),
    mk(sm(S_Y1), sm(S_Y1), S_T3),
    mk(sm(S_CA), sm(S_T2), S_T4),
    mk(sm(S_T1), sm(S_T2), S_T5),
    mk(sm(S_T0) | sm(S_T1), sm(S_T4) | sm(S_T3) | sm(S_T1), S_T6)
  };

  localparam src_mask_t DBL_RX = sm(S_T0) | sm(S_T1);
  localparam src_mask_t DBL_RY = sm(S_T5) | sm(S_T6);
  localparam src_mask_t DBL_RZ = sm(S_T2);

  // Addition: T1^Y1 = T1, T2^X1 = T2, T3 = C, T5 = D, T6 = Z3, T0 = E, T1 = T1^2
  localparam uop_t ADD_ROM [NMUL_ADD] = '{
    mk(sm(S_Z1), sm(S_Z1), S_T0),
    mk(sm(S_Y2), sm(S_T0), S_T1),
    mk(sm(S_X2), sm(S_Z1), S_T2),
    mk(sm(S_Z1), sm(S_T2) | sm(S_X1), S_T3),
    mk(sm(S_CA), sm(S_T0), S_T4),
    mk(sm(S_T2) | sm(S_X1), sm(S_T2) | sm(S_X1), S_T5),
    mk(sm(S_T5), sm(S_T3) | sm(S_T4), S_T5),
    mk(sm(S_T3), sm(S_T3), S_T6),
    mk(sm(S_T1) | sm(S_Y1), sm(S_T3), S_T0),
    mk(sm(S_T1) | sm(S_Y1), sm(S_T1) | sm(S_Y1), S_T1),
    mk(sm(S_X2), sm(S_T6), S_T2),
    mk(sm(S_T6), sm(S_T6), S_T4),
    mk(sm(S_X2) | sm(S_Y2), sm(S_T4), S_T4),
    mk(sm(S_T0) | sm(S_T6), sm(S_T1) | sm(S_T5) | sm(S_T0) | sm(S_T2), S_T7)
  };

  localparam src_mask_t ADD_RX = sm(S_T1) | sm(S_T5) | sm(S_T0);
  localparam src_mask_t ADD_RY = sm(S_T7) | sm(S_T4);
  localparam src_mask_t ADD_RZ = sm(S_T6);

endpackage

// File: rtl/ld_point_alu_seq_if.sv
// Start/busy/done handshake and point buses between the scalar-mult controller and the ALU.
interface ld_point_alu_seq_if #(
  parameter int M = 4
);
  logic           start;
  logic           op;
  logic [3*M-1:0] A;
  logic [3*M-1:0] B;
  logic [3*M-1:0] R;
  logic           busy;
  logic           done;
  logic           degen;

  modport master (output start, op, A, B, input R, busy, done, degen);
  modport slave  (input start, op, A, B, output R, busy, done, degen);
endinterface

// File: rtl/gf2m_mul_serial.sv
// MSB-first bit-serial GF(2^M) multiplier: operands latched on load, M shift-add-reduce steps.
// p/valid present the final step's value so the caller can store it on that same edge.
module gf2m_mul_serial
  import ld_pkg::*;
#(
  parameter int         M    = 4,
  parameter logic [M:0] POLY = 5'h13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic [M-1:0] p,
  output logic         valid
);
  localparam int CW = $clog2(M + 1);

  logic [M-1:0]  r_a;
  logic [M-1:0]  r_b;
  logic [M-1:0]  r_acc;
  logic [CW-1:0] r_cnt;
  logic [M-1:0]  w_sh;
  logic [M-1:0]  w_next;

  assign w_sh   = {r_acc[M-2:0], 1'b0} ^ (r_acc[M-1] ? POLY[M-1:0] : '0);
  assign w_next = w_sh ^ (r_b[M-1] ? r_a : '0);
  assign p      = w_next;
  assign valid  = (r_cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (load) begin
      r_a   <= a;
      r_b   <= b;
      r_acc <= '0;
      r_cnt <= CW'(M);
    end else if (r_cnt != '0) begin
      r_acc <= w_next;
      r_b   <= {r_b[M-2:0], 1'b0};
      r_cnt <= r_cnt - CW'(1);
    end
  end
endmodule

// File: rtl/ld_point_alu_seq.sv
// Sequential Lopez-Dahab point ALU: mixed add (B + A) or double (2A) over GF(2^M),
// every field product computed on one shared serial multiplier under a ROM microprogram.
//
// state     | meaning
// ST_IDLE   | waiting for start; done cycle also lands here with busy still high
// ST_RUN    | stepping microprogram: one load cycle then M multiplier steps per uop
// ST_FINISH | scratch final; assemble R and degen, pulse done on the next edge
module ld_point_alu_seq
  import ld_pkg::*;
#(
  parameter int         M       = 4,
  parameter logic [M:0] POLY    = 5'h13,
  parameter logic [M-1:0] CURVE_A = 4'h4,
  parameter logic [M-1:0] CURVE_B = 4'h1
) (
  input logic clk,
  input logic rst,
  ld_point_alu_seq_if.slave bus
);
  localparam logic [M-1:0] ONE = {{(M-1){1'b0}}, 1'b1};

  state_e         r_state;
  logic           r_ld;
  logic [3:0]     r_pc;
  logic           r_op;
  logic           r_zero;
  logic [M-1:0]   r_x1, r_y1, r_z1, r_x2, r_y2;
  logic [M-1:0]   r_t [NSCR];
  logic [3*M-1:0] r_r;
  logic           r_busy, r_done, r_degen;

  uop_t           w_uop;
  logic           w_last;
  logic [M-1:0]   w_src [NSRC];
  logic [M-1:0]   w_opa, w_opb, w_rx, w_ry, w_rz, w_p;
  src_mask_t      w_mx, w_my, w_mz;
  logic           w_load, w_valid;

  assign w_uop  = r_op ? DBL_ROM[r_pc] : ADD_ROM[r_pc];
  assign w_last = (r_pc == (r_op ? 4'(NMUL_DBL - 1) : 4'(NMUL_ADD - 1)));
  assign w_mx   = r_op ? DBL_RX : ADD_RX;
  assign w_my   = r_op ? DBL_RY : ADD_RY;
  assign w_mz   = r_op ? DBL_RZ : ADD_RZ;
  assign w_load = (r_state == ST_RUN) && r_ld;

  always_comb begin
    w_src[S_X1]  = r_x1;
    w_src[S_Y1]  = r_y1;
    w_src[S_Z1]  = r_z1;
    w_src[S_X2]  = r_x2;
    w_src[S_Y2]  = r_y2;
    w_src[S_ONE] = ONE;
    w_src[S_CA]  = CURVE_A;
    w_src[S_CB]  = CURVE_B;
    for (int i = 0; i < NSCR; i++) w_src[int'(S_T0) + i] = r_t[i];
  end

  always_comb begin
    w_opa = '0;
    w_opb = '0;
    w_rx  = '0;
    w_ry  = '0;
    w_rz  = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (w_uop.sel_a[i]) w_opa = w_opa ^ w_src[i];
      if (w_uop.sel_b[i]) w_opb = w_opb ^ w_src[i];
      if (w_mx[i])        w_rx  = w_rx ^ w_src[i];
      if (w_my[i])        w_ry  = w_ry ^ w_src[i];
      if (w_mz[i])        w_rz  = w_rz ^ w_src[i];
    end
  end

  gf2m_mul_serial #(.M(M), .POLY(POLY)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .load  (w_load),
    .a     (w_opa),
    .b     (w_opb),
    .p     (w_p),
    .valid (w_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ld    <= 1'b0;
      r_pc    <= '0;
      r_op    <= 1'b0;
      r_zero  <= 1'b0;
      r_x1    <= '0;
      r_y1    <= '0;
      r_z1    <= '0;
      r_x2    <= '0;
      r_y2    <= '0;
      for (int i = 0; i < NSCR; i++) r_t[i] <= '0;
      r_r     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_degen <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_done) r_busy <= 1'b0;
          if (bus.start && !r_busy) begin
            r_op    <= bus.op;
            // Doubling takes A as affine: its Z only flags infinity.
            r_zero  <= bus.op ? (bus.A[2*M +: M] == '0) : (bus.B[2*M +: M] == '0);
            r_x1    <= bus.op ? bus.A[0 +: M] : bus.B[0 +: M];
            r_y1    <= bus.op ? bus.A[M +: M] : bus.B[M +: M];
            r_z1    <= bus.op ? ONE : bus.B[2*M +: M];
            r_x2    <= bus.A[0 +: M];
            r_y2    <= bus.A[M +: M];
            r_pc    <= '0;
            r_ld    <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (r_ld) r_ld <= 1'b0;
          if (w_valid) begin
            r_t[w_uop.dst] <= w_p;
            if (w_last) begin
              r_state <= ST_FINISH;
            end else begin
              r_pc <= r_pc + 4'd1;
              r_ld <= 1'b1;
            end
          end
        end
        ST_FINISH: begin
          if (r_zero) begin
            r_r     <= r_op ? '0 : {ONE, r_y2, r_x2};
            r_degen <= 1'b0;
          end else begin
            r_r     <= {w_rz, w_ry, w_rx};
            r_degen <= !r_op && (w_rz == '0);
          end
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.R     = r_r;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.degen = r_degen;
endmodule
